// File: rtl/ttc_rx_pkg.sv
// Shared definitions for the TTC serial frame receive path: default frame width,
// bit-order selectors and the receiver state encoding.
package ttc_rx_pkg;

   localparam int FRAME_W_DEFAULT = 56;

   localparam bit BIT_MSB_FIRST = 1'b1;
   localparam bit BIT_LSB_FIRST = 1'b0;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

endpackage

// File: rtl/frame_hold_reg.sv
// Single-entry valid/ready holding buffer. A load request that finds the buffer
// occupied and not being drained is dropped and flagged with a one-cycle overflow pulse.
module frame_hold_reg
   import ttc_rx_pkg::*;
#(
   parameter int WIDTH = FRAME_W_DEFAULT + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             loadReq_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             overflow_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overflow_q, overflow_d;
   logic             load;

   // A drain and a new load in the same cycle keeps valid high with the new contents.
   always_comb begin
      load       = loadReq_i & (~valid_q | ready_i);
      data_d     = data_q;
      valid_d    = valid_q & ~ready_i;
      overflow_d = loadReq_i & valid_q & ~ready_i;
      if (load) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Gated serial-to-parallel frame receiver with selectable bit order, per-frame block
// error tagging, abort detection and a valid/ready holding register on the output.
module serial_frame_rx
   import ttc_rx_pkg::*;
#(
   parameter int FRAME_W   = FRAME_W_DEFAULT,
   parameter bit MSB_FIRST = BIT_MSB_FIRST,
   parameter int CNT_W     = 8
) (
   input  logic               ClkI,
   input  logic               RstI,
   input  logic               DataI,
   input  logic               EnI,
   input  logic               BlockErrI,
   output logic [FRAME_W-1:0] FrameO,
   output logic               FrameErrO,
   output logic               FrameValidO,
   input  logic               FrameReadyI,
   output logic               AbortO,
   output logic               OverflowO,
   output logic [CNT_W-1:0]   BitCntO
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

   rx_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] shift_q, shift_d;
   logic               errAcc_q, errAcc_d;

   logic [CNT_W-1:0]   bitIdx;
   logic [FRAME_W-1:0] frameNext;
   logic               lastBit;
   logic               complete;
   logic               abort;
   logic [FRAME_W:0]   holdIn;
   logic [FRAME_W:0]   holdOut;

   // Merge the current serial bit into its slot so a completing frame includes it.
   always_comb begin
      bitIdx    = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;
      frameNext = shift_q;
      for (int i = 0; i < FRAME_W; i++) begin
         if (CNT_W'(i) == bitIdx) begin
            frameNext[i] = DataI;
         end
      end
      lastBit = (cnt_q == LAST_IDX);
      holdIn  = {errAcc_q | BlockErrI, frameNext};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      errAcc_d = errAcc_q;
      complete = 1'b0;
      abort    = 1'b0;
      case (state_q)
         IDLE, SHIFT: begin
            if (EnI) begin
               state_d = SHIFT;
               if (lastBit) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  shift_d  = '0;
                  errAcc_d = 1'b0;
               end else begin
                  cnt_d    = cnt_q + CNT_W'(1);
                  shift_d  = frameNext;
                  errAcc_d = errAcc_q | BlockErrI;
               end
            end else begin
               // Gate dropped: a partially collected frame is thrown away.
               state_d  = IDLE;
               cnt_d    = '0;
               shift_d  = '0;
               errAcc_d = 1'b0;
               abort    = (state_q == SHIFT) && (cnt_q != '0);
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            shift_d  = '0;
            errAcc_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ClkI or posedge RstI) begin
      if (RstI) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         errAcc_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         errAcc_q <= errAcc_d;
      end
   end

   frame_hold_reg #(
      .WIDTH(FRAME_W + 1)
   ) uHold (
      .clk_i     (ClkI),
      .rst_i     (RstI),
      .loadReq_i (complete),
      .data_i    (holdIn),
      .ready_i   (FrameReadyI),
      .data_o    (holdOut),
      .valid_o   (FrameValidO),
      .overflow_o(OverflowO)
   );

   assign FrameO    = holdOut[FRAME_W-1:0];
   assign FrameErrO = holdOut[FRAME_W];
   assign AbortO    = abort;
   assign BitCntO   = cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Drives one serial stream into an MSB-first and an LSB-first receiver and checks both
// against a cycle model with a scoreboard of expected held frames.
module tb_serial_frame_rx;

   localparam int W = 56;

   typedef struct packed {
      logic         err;
      logic [W-1:0] msb;
      logic [W-1:0] lsb;
   } exp_t;

   logic ClkI = 1'b0;
   logic RstI;
   logic DataI, EnI, BlockErrI, FrameReadyI;

   logic [W-1:0] FrameOM, FrameOL;
   logic         FrameErrOM, FrameErrOL;
   logic         FrameValidOM, FrameValidOL;
   logic         AbortOM, AbortOL;
   logic         OverflowOM, OverflowOL;
   logic [7:0]   BitCntOM, BitCntOL;

   int checks = 0;
   int errors = 0;
   int ovfSeen = 0;

   exp_t         expQ[$];
   logic [W-1:0] mShiftMsb, mShiftLsb, hMsb, hLsb;
   logic         mErrAcc, mValid, mOvf, mLoaded, hErr;
   int           mCnt;

   always #5 ClkI = ~ClkI;

   serial_frame_rx #(.FRAME_W(W), .MSB_FIRST(1'b1), .CNT_W(8)) dutMsb (
      .ClkI(ClkI), .RstI(RstI), .DataI(DataI), .EnI(EnI), .BlockErrI(BlockErrI),
      .FrameO(FrameOM), .FrameErrO(FrameErrOM), .FrameValidO(FrameValidOM),
      .FrameReadyI(FrameReadyI), .AbortO(AbortOM), .OverflowO(OverflowOM), .BitCntO(BitCntOM)
   );

   serial_frame_rx #(.FRAME_W(W), .MSB_FIRST(1'b0), .CNT_W(8)) dutLsb (
      .ClkI(ClkI), .RstI(RstI), .DataI(DataI), .EnI(EnI), .BlockErrI(BlockErrI),
      .FrameO(FrameOL), .FrameErrO(FrameErrOL), .FrameValidO(FrameValidOL),
      .FrameReadyI(FrameReadyI), .AbortO(AbortOL), .OverflowO(OverflowOL), .BitCntO(BitCntOL)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [W-1:0] bitRev(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   task automatic resetModel();
      mShiftMsb = '0;
      mShiftLsb = '0;
      hMsb      = '0;
      hLsb      = '0;
      hErr      = 1'b0;
      mErrAcc   = 1'b0;
      mValid    = 1'b0;
      mOvf      = 1'b0;
      mLoaded   = 1'b0;
      mCnt      = 0;
      expQ.delete();
   endtask

   // One clock cycle: drive inputs at the falling edge, compare outputs, then step the model.
   task automatic applyStimulus(input logic en, input logic d, input logic be, input logic rdy);
      exp_t e;
      logic load;
      @(negedge ClkI);
      EnI         = en;
      DataI       = d;
      BlockErrI   = be;
      FrameReadyI = rdy;
      #1;
      if (mLoaded) begin
         checkOutput("sb_nonempty", 64'(expQ.size() != 0), 64'd1);
         if (expQ.size() != 0) begin
            e    = expQ.pop_front();
            hMsb = e.msb;
            hLsb = e.lsb;
            hErr = e.err;
         end
      end
      checkOutput("valid", 64'(FrameValidOM), 64'(mValid));
      checkOutput("frame_msb", 64'(FrameOM), 64'(hMsb));
      checkOutput("err", 64'(FrameErrOM), 64'(hErr));
      checkOutput("overflow", 64'(OverflowOM), 64'(mOvf));
      checkOutput("abort", 64'(AbortOM), 64'(!en && mCnt != 0));
      checkOutput("bitcnt", 64'(BitCntOM), 64'(mCnt));
      checkOutput("valid_lsb", 64'(FrameValidOL), 64'(mValid));
      checkOutput("frame_lsb", 64'(FrameOL), 64'(hLsb));
      checkOutput("err_lsb", 64'(FrameErrOL), 64'(hErr));
      if (OverflowOM) ovfSeen++;

      if (en && mCnt == W - 1) begin
         e.msb    = mShiftMsb;
         e.msb[0] = d;
         e.lsb    = mShiftLsb;
         e.lsb[W-1] = d;
         e.err    = mErrAcc | be;
         load     = !mValid || rdy;
         if (load) expQ.push_back(e);
         mLoaded  = load;
         mOvf     = !load;
         mValid   = 1'b1;
         mCnt     = 0;
         mErrAcc  = 1'b0;
         mShiftMsb = '0;
         mShiftLsb = '0;
      end else begin
         mLoaded = 1'b0;
         mOvf    = 1'b0;
         if (mValid && rdy) mValid = 1'b0;
         if (en) begin
            mShiftMsb[W-1-mCnt] = d;
            mShiftLsb[mCnt]     = d;
            mErrAcc = mErrAcc | be;
            mCnt++;
         end else begin
            mCnt      = 0;
            mErrAcc   = 1'b0;
            mShiftMsb = '0;
            mShiftLsb = '0;
         end
      end
   endtask

   // Serial stream is the value's bits from MSB downward; errAt < 0 means no block error.
   task automatic sendBits(input logic [W-1:0] v, input int first, input int last,
                           input int errAt, input logic rdy);
      for (int i = first; i <= last; i++) begin
         applyStimulus(1'b1, v[W-1-i], (i == errAt), rdy);
      end
   endtask

   task automatic sendFrame(input logic [W-1:0] v, input int errAt, input logic rdy);
      sendBits(v, 0, W - 1, errAt, rdy);
   endtask

   function automatic logic [W-1:0] randFrame();
      return W'({$urandom(), $urandom()});
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [W-1:0] fA, fB, fC, fD, fE, fF, fG, fH, fI, fJ, fK, fL, fM;
      int ovfBefore;

      fA = 56'hA55A0FF0123456;
      fB = randFrame(); fC = randFrame(); fD = randFrame(); fE = randFrame();
      fF = randFrame(); fG = randFrame(); fH = randFrame(); fI = randFrame();
      fJ = randFrame(); fK = randFrame(); fL = randFrame(); fM = randFrame();

      RstI = 1'b1; EnI = 1'b0; DataI = 1'b0; BlockErrI = 1'b0; FrameReadyI = 1'b0;
      resetModel();
      repeat (2) @(negedge ClkI);
      RstI = 1'b0;

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_valid", 64'(FrameValidOM), 64'd0);
      checkOutput("reset_frame", 64'(FrameOM), 64'd0);
      checkOutput("reset_bitcnt", 64'(BitCntOM), 64'd0);

      $display("[TB] basic MSB/LSB frame");
      sendFrame(fA, -1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("basic_valid", 64'(FrameValidOM), 64'd1);
      checkOutput("basic_msb_const", 64'(FrameOM), 64'(fA));
      checkOutput("basic_lsb_rev", 64'(FrameOL), 64'(bitRev(fA)));
      checkOutput("basic_err", 64'(FrameErrOM), 64'd0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("accept_clears_valid", 64'(FrameValidOM), 64'd0);
      checkOutput("accept_keeps_frame", 64'(FrameOM), 64'(fA));

      $display("[TB] block error then clean back-to-back frame");
      sendFrame(fB, 20, 1'b0);
      sendBits(fC, 0, 0, -1, 1'b1);
      checkOutput("blockerr_flag", 64'(FrameErrOM), 64'd1);
      sendBits(fC, 1, W - 1, -1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("clean_flag", 64'(FrameErrOM), 64'd0);
      checkOutput("clean_frame", 64'(FrameOM), 64'(fC));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] three frames, consumer stalled");
      ovfBefore = ovfSeen;
      sendFrame(fD, -1, 1'b0);
      sendFrame(fE, -1, 1'b0);
      sendFrame(fF, -1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf_pulses", 64'(ovfSeen - ovfBefore), 64'd2);
      checkOutput("ovf_keeps_first", 64'(FrameOM), 64'(fD));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] three frames, consumer ready");
      ovfBefore = ovfSeen;
      sendFrame(fG, -1, 1'b1);
      sendFrame(fH, -1, 1'b1);
      sendFrame(fI, -1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("no_ovf_pulses", 64'(ovfSeen - ovfBefore), 64'd0);
      checkOutput("ready_last_frame", 64'(FrameOM), 64'(fI));

      $display("[TB] abort with a held frame");
      sendBits(fJ, 0, 29, -1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort_pulse", 64'(AbortOM), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort_single", 64'(AbortOM), 64'd0);
      checkOutput("abort_bitcnt", 64'(BitCntOM), 64'd0);
      checkOutput("abort_valid_kept", 64'(FrameValidOM), 64'd1);
      checkOutput("abort_frame_kept", 64'(FrameOM), 64'(fI));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      sendFrame(fK, -1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("after_abort_frame", 64'(FrameOM), 64'(fK));

      $display("[TB] async reset mid-frame");
      sendBits(fL, 0, 39, -1, 1'b0);
      #2;
      RstI = 1'b1;
      EnI  = 1'b0;
      #1;
      checkOutput("arst_valid", 64'(FrameValidOM), 64'd0);
      checkOutput("arst_frame", 64'(FrameOM), 64'd0);
      checkOutput("arst_bitcnt", 64'(BitCntOM), 64'd0);
      checkOutput("arst_abort", 64'(AbortOM), 64'd0);
      checkOutput("arst_lsb_frame", 64'(FrameOL), 64'd0);
      @(negedge ClkI);
      RstI = 1'b0;
      resetModel();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      sendFrame(fM, -1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_frame", 64'(FrameOM), 64'(fM));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
